// File: rtl/frame_sync_pkg.sv
// Shared frame-sync definitions: FSM states, the default sync header and a popcount
// helper used by the error-tolerant header compare.
package frame_sync_pkg;

  typedef enum logic [1:0] {SEARCH, PAYLOAD, CHECK} state_e;

  localparam int SYNC_WIDTH = 32;
  localparam logic [SYNC_WIDTH-1:0] SYNC_HEADER_DEFAULT = 32'h1ACFFC1D;

  function automatic int unsigned popcount(input logic [SYNC_WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < SYNC_WIDTH; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_word_match.sv
// Header comparator: exact match by default, or up to SYNC_ERR_TOL bit errors
// when FRAME_SYNC_ERR_TOL_EN is defined.
module sync_word_match
  import frame_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] SYNC_HEADER  = SYNC_HEADER_DEFAULT,
  parameter int                    SYNC_ERR_TOL = 2
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic                  match_o
);

`ifdef FRAME_SYNC_ERR_TOL_EN
  assign match_o = (popcount(word_i ^ SYNC_HEADER) <= 32'(SYNC_ERR_TOL));
`else
  assign match_o = (word_i == SYNC_HEADER);
`endif

endmodule

// File: rtl/frame_sync_detect.sv
// Receive-side frame synchroniser: finds the sync header, strips it, forwards
// BLOCK_SIZE_IN_WORDS payload words per frame and flywheels over missed headers.
// Optional tolerant header match: FRAME_SYNC_ERR_TOL_EN.
module frame_sync_detect
  import frame_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH          = 32,
  parameter logic [DATA_WIDTH-1:0] SYNC_HEADER         = SYNC_HEADER_DEFAULT,
  parameter int                    BLOCK_SIZE_IN_WORDS = 256,
  parameter int                    MISS_LIMIT          = 3,
  parameter int                    SYNC_ERR_TOL        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  locked,
  output logic                  sync_miss
);

  localparam int CNT_W  = $clog2(BLOCK_SIZE_IN_WORDS);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BLOCK_SIZE_IN_WORDS - 1);
  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);

  state_e                  state_q;
  logic [CNT_W-1:0]        word_cnt_q;
  logic [MISS_W-1:0]       miss_cnt_q;
  logic [MISS_W-1:0]       miss_cnt_d;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    valid_out_q;
  logic                    last_out_q;
  logic                    locked_q;
  logic                    sync_miss_q;

  logic                    hdr_match;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    load_out;

  sync_word_match #(
    .DATA_WIDTH   (DATA_WIDTH),
    .SYNC_HEADER  (SYNC_HEADER),
    .SYNC_ERR_TOL (SYNC_ERR_TOL)
  ) u_match (
    .word_i  (data_in),
    .match_o (hdr_match)
  );

  // Header words are always consumed; payload words wait for room in the output register.
  assign ready_out  = (state_q == PAYLOAD) ? (!valid_out_q || ready_in) : 1'b1;
  assign in_xfer    = valid_in && ready_out;
  assign out_xfer   = valid_out_q && ready_in;
  assign load_out   = in_xfer && (state_q == PAYLOAD);
  assign miss_cnt_d = miss_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      word_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      locked_q    <= 1'b0;
      sync_miss_q <= 1'b0;
    end else begin
      sync_miss_q <= 1'b0;

      if (load_out) begin
        data_out_q  <= data_in;
        valid_out_q <= 1'b1;
        last_out_q  <= (word_cnt_q == LAST_IDX);
      end else if (out_xfer) begin
        valid_out_q <= 1'b0;
        last_out_q  <= 1'b0;
      end

      if (in_xfer) begin
        case (state_q)
          SEARCH: begin
            if (hdr_match) begin
              state_q    <= PAYLOAD;
              word_cnt_q <= '0;
              miss_cnt_q <= '0;
              locked_q   <= 1'b1;
            end
          end
          PAYLOAD: begin
            if (word_cnt_q == LAST_IDX) begin
              word_cnt_q <= '0;
              state_q    <= CHECK;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
          CHECK: begin
            if (hdr_match) begin
              miss_cnt_q <= '0;
              state_q    <= PAYLOAD;
            end else begin
              sync_miss_q <= 1'b1;
              // Too many misses in a row: drop lock and hunt; otherwise flywheel on.
              if (miss_cnt_d == MISS_MAX) begin
                miss_cnt_q <= '0;
                locked_q   <= 1'b0;
                state_q    <= SEARCH;
              end else begin
                miss_cnt_q <= miss_cnt_d;
                state_q    <= PAYLOAD;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;
  assign locked    = locked_q;
  assign sync_miss = sync_miss_q;

endmodule

// File: tb/tb_frame_sync_detect.sv
// Directed bench for frame_sync_detect: acquisition, back-to-back frames under
// backpressure, flywheel loss of lock, tolerant header, mid-frame reset, gapped input.
module tb_frame_sync_detect;

  localparam logic [31:0] HDR = 32'h1ACFFC1D;
  localparam int BS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        last_out;
  logic        locked;
  logic        sync_miss;

  int checks = 0;
  int passed = 0;

  logic [32:0] out_q[$];
  int          miss_pulses = 0;
  int          stall_err = 0;
  bit          stall_pending = 1'b0;
  logic [32:0] held;
  bit          toggle_ready = 1'b0;

  frame_sync_detect dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .last_out  (last_out),
    .locked    (locked),
    .sync_miss (sync_miss)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (toggle_ready) ready_in = ~ready_in;
  end

  // Output monitor sampled on the falling edge, between input updates and the next active edge.
  always @(negedge clk) begin
    if (stall_pending) begin
      if (!(valid_out === 1'b1 && {last_out, data_out} === held)) stall_err++;
    end
    stall_pending = (valid_out === 1'b1) && (ready_in === 1'b0);
    held = {last_out, data_out};
    if (valid_out === 1'b1 && ready_in === 1'b1) out_q.push_back({last_out, data_out});
    if (sync_miss === 1'b1) miss_pulses++;
  end

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    int t;
    if (gap && ($urandom_range(0, 1) == 1)) begin
      valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
    data_in  = w;
    valid_in = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (ready_out === 1'b1) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
      if (t > 200) begin
        checks++;
        $display("FAIL send_word timeout: ready_out=%b required 1 within 200 cycles", ready_out);
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base, input bit gap);
    send_word(hdr, gap);
    for (int i = 0; i < BS; i++) send_word(base + 32'(i), gap);
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid_out, last_out, locked, sync_miss, ready_out} !== 5'b00001 || data_out !== 32'd0) begin
      $display("FAIL reset: v=%b l=%b lk=%b sm=%b ro=%b d=%h required 0 0 0 0 1 00000000",
               valid_out, last_out, locked, sync_miss, ready_out, data_out);
    end else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_acquire;
    int bad;
    out_q.delete(); miss_pulses = 0;
    for (int i = 0; i < 5; i++) send_word(32'h0, 1'b0);
    checks++;
    if (locked !== 1'b0 || out_q.size() != 0) begin
      $display("FAIL acquire_garbage: locked=%b outs=%0d required 0 0", locked, out_q.size());
    end else passed++;
    send_word(HDR, 1'b0);
    checks++;
    if (locked !== 1'b1) $display("FAIL acquire_lock: locked=%b required 1", locked);
    else passed++;
    for (int i = 0; i < BS; i++) send_word(32'(i), 1'b0);
    idle(4);
    checks++;
    if (out_q.size() != BS) $display("FAIL acquire_count: got %0d required %0d", out_q.size(), BS);
    else passed++;
    bad = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (out_q[i] !== {(i == BS - 1), 32'(i)}) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL acquire_data: %0d bad words, required 0", bad);
    else passed++;
    checks++;
    if (miss_pulses != 0 || locked !== 1'b1) begin
      $display("FAIL acquire_status: misses=%0d locked=%b required 0 1", miss_pulses, locked);
    end else passed++;
  endtask

  task automatic test_back_to_back;
    int bad;
    out_q.delete(); miss_pulses = 0; stall_err = 0;
    toggle_ready = 1'b1;
    send_frame(HDR, 32'd1000, 1'b0);
    send_frame(HDR, 32'd2000, 1'b0);
    idle(6);
    toggle_ready = 1'b0;
    ready_in = 1'b1;
    idle(4);
    checks++;
    if (out_q.size() != 2 * BS) $display("FAIL b2b_count: got %0d required %0d", out_q.size(), 2 * BS);
    else passed++;
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 2 * BS; i++) begin
      if (out_q[i] !== {(i % BS == BS - 1), (i < BS ? 32'd1000 : 32'd2000) + 32'(i % BS)}) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL b2b_data: %0d bad words, required 0", bad);
    else passed++;
    checks++;
    if (stall_err != 0) $display("FAIL b2b_stable: %0d unstable stalls, required 0", stall_err);
    else passed++;
    checks++;
    if (miss_pulses != 0) $display("FAIL b2b_miss: got %0d pulses required 0", miss_pulses);
    else passed++;
  endtask

  task automatic test_flywheel;
    int bad;
    out_q.delete(); miss_pulses = 0;
    send_frame(32'hFFFFFFFF, 32'd3000, 1'b0);
    send_frame(32'hFFFFFFFF, 32'd4000, 1'b0);
    checks++;
    if (locked !== 1'b1 || miss_pulses != 2) begin
      $display("FAIL fly_hold: locked=%b misses=%0d required 1 2", locked, miss_pulses);
    end else passed++;
    send_frame(32'hFFFFFFFF, 32'd5000, 1'b0);
    idle(4);
    checks++;
    if (locked !== 1'b0 || miss_pulses != 3) begin
      $display("FAIL fly_lost: locked=%b misses=%0d required 0 3", locked, miss_pulses);
    end else passed++;
    checks++;
    if (out_q.size() != 2 * BS) $display("FAIL fly_count: got %0d required %0d", out_q.size(), 2 * BS);
    else passed++;
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 2 * BS; i++) begin
      if (out_q[i] !== {(i % BS == BS - 1), (i < BS ? 32'd3000 : 32'd4000) + 32'(i % BS)}) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL fly_data: %0d bad words, required 0", bad);
    else passed++;
  endtask

  task automatic test_tolerance;
    int exp_after_1bit;
    out_q.delete();
    send_frame(HDR, 32'd0, 1'b0);
    miss_pulses = 0;
    send_frame(32'h1ACFFC1C, 32'd100, 1'b0);
    idle(4);
`ifdef FRAME_SYNC_ERR_TOL_EN
    exp_after_1bit = 0;
`else
    exp_after_1bit = 1;
`endif
    checks++;
    if (miss_pulses != exp_after_1bit) begin
      $display("FAIL tol_1bit: misses=%0d required %0d", miss_pulses, exp_after_1bit);
    end else passed++;
    send_frame(32'h1ACFFC12, 32'd200, 1'b0);
    idle(4);
    checks++;
    if (miss_pulses != exp_after_1bit + 1) begin
      $display("FAIL tol_4bit: misses=%0d required %0d", miss_pulses, exp_after_1bit + 1);
    end else passed++;
    checks++;
    if (out_q.size() != 3 * BS || out_q[BS] !== {1'b0, 32'd100} || out_q[2 * BS] !== {1'b0, 32'd200}) begin
      $display("FAIL tol_data: outs=%0d required %0d with frames at 100 and 200", out_q.size(), 3 * BS);
    end else passed++;
  endtask

  task automatic test_reset_midframe;
    int bad;
    send_word(HDR, 1'b0);
    for (int i = 0; i < 100; i++) send_word(32'd6000 + 32'(i), 1'b0);
    valid_in = 1'b0;
    ready_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || locked !== 1'b0 || ready_out !== 1'b1) begin
      $display("FAIL rst_mid: valid_out=%b locked=%b ready_out=%b required 0 0 1", valid_out, locked, ready_out);
    end else passed++;
    @(posedge clk); #1;
    ready_in = 1'b1;
    out_q.delete();
    send_word(32'd6200, 1'b0);
    send_word(32'd6201, 1'b0);
    idle(3);
    checks++;
    if (out_q.size() != 0 || locked !== 1'b0) begin
      $display("FAIL rst_search: outs=%0d locked=%b required 0 0", out_q.size(), locked);
    end else passed++;
    send_frame(HDR, 32'd7000, 1'b0);
    idle(4);
    bad = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (out_q[i] !== {(i == BS - 1), 32'd7000 + 32'(i)}) bad++;
    end
    checks++;
    if (out_q.size() != BS || bad != 0) begin
      $display("FAIL rst_refill: outs=%0d bad=%0d required %0d 0", out_q.size(), bad, BS);
    end else passed++;
  endtask

  task automatic test_gapped;
    int bad;
    out_q.delete(); miss_pulses = 0;
    send_frame(HDR, 32'd0, 1'b1);
    idle(4);
    bad = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (out_q[i] !== {(i == BS - 1), 32'(i)}) bad++;
    end
    checks++;
    if (out_q.size() != BS || bad != 0 || miss_pulses != 0) begin
      $display("FAIL gapped: outs=%0d bad=%0d misses=%0d required %0d 0 0", out_q.size(), bad, miss_pulses, BS);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_back_to_back();
    test_flywheel();
    test_tolerance();
    test_reset_midframe();
    test_gapped();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
